// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer shared by the control unit (cpu) and an I/O port.
// Round-robin arbitration in IDLE, then a fixed ACCESS/CAPTURE/DONE timeline.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       io_req,
    input  logic       io_we,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wdata,
    input  logic [7:0] mem_rdata,
    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mdr_read,
    output logic [7:0] io_rdata,
    output logic       cpu_done,
    output logic       io_done,
    output logic       busy,
    output logic       grant_io
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       we_q, we_d;
    logic       last_io_q, last_io_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] io_rdata_q, io_rdata_d;
    logic       mem_en_q, mem_en_d;
    logic       mem_we_q, mem_we_d;
    logic       mdr_read_q, mdr_read_d;
    logic       cpu_done_q, cpu_done_d;
    logic       io_done_q, io_done_d;
    logic       busy_q, busy_d;
    logic       pick_io;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        last_io_d  = last_io_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        io_rdata_d = io_rdata_q;
        pick_io    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || io_req) begin
                    // io wins alone, or on a tie when cpu was served last
                    pick_io = io_req && (!cpu_req || !last_io_q);
                    owner_d = pick_io;
                    we_d    = pick_io ? io_we    : cpu_we;
                    addr_d  = pick_io ? io_addr  : cpu_addr;
                    wdata_d = pick_io ? io_wdata : cpu_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) state_d = we_q ? DONE : CAPTURE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            CAPTURE: begin
                if (owner_q) io_rdata_d = mem_rdata;
                state_d = DONE;
            end
            DONE: begin
                last_io_d = owner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of the next-state decode, so they
        // line up with state_q without any path from the request inputs.
        mem_en_d   = (state_d == ACCESS) || (state_d == CAPTURE);
        mem_we_d   = (state_d == ACCESS) && we_d;
        mdr_read_d = (state_d == CAPTURE) && !owner_d;
        cpu_done_d = (state_d == DONE) && !owner_d;
        io_done_d  = (state_d == DONE) && owner_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            last_io_q  <= 1'b1;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            io_rdata_q <= 8'h00;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mdr_read_q <= 1'b0;
            cpu_done_q <= 1'b0;
            io_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            last_io_q  <= last_io_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            io_rdata_q <= io_rdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mdr_read_q <= mdr_read_d;
            cpu_done_q <= cpu_done_d;
            io_done_q  <= io_done_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mdr_read  = mdr_read_q;
    assign io_rdata  = io_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign io_done   = io_done_q;
    assign busy      = busy_q;
    assign grant_io  = owner_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 1 and 0) on shared stimulus,
// a per-cycle transaction-timeline model, and directed literal checks.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 0, cpu_we = 0, io_req = 0, io_we = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0, io_addr = 0, io_wdata = 0, mem_rdata = 0;

    logic       mem_en_o [2], mem_we_o [2], mdr_read_o [2], cpu_done_o [2];
    logic       io_done_o [2], busy_o [2], grant_io_o [2];
    logic [7:0] mem_addr_o [2], mem_wdata_o [2], io_rdata_o [2];

    int n_chk = 0, n_fail = 0, cyc = 0;

    // model state per instance
    int         W [2] = '{1, 0};
    bit         m_act [2] = '{0, 0};
    int         m_t [2] = '{0, 0};
    bit         m_own [2] = '{0, 0};
    bit         m_we [2] = '{0, 0};
    bit         m_last [2] = '{1, 1};
    logic [7:0] m_addr [2] = '{0, 0};
    logic [7:0] m_wdata [2] = '{0, 0};
    logic [7:0] m_rd [2] = '{0, 0};

    // observation counters used by the directed checks
    int en_cnt [2], we_cnt [2], mdr_cnt [2], done_cnt [2], last_cpu_done [2];
    logic [7:0] rd_at_done [2];
    int order_q[$];

    mem_access_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .mem_rdata(mem_rdata),
        .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mdr_read(mdr_read_o[0]), .io_rdata(io_rdata_o[0]),
        .cpu_done(cpu_done_o[0]), .io_done(io_done_o[0]), .busy(busy_o[0]),
        .grant_io(grant_io_o[0])
    );

    mem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .mem_rdata(mem_rdata),
        .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mdr_read(mdr_read_o[1]), .io_rdata(io_rdata_o[1]),
        .cpu_done(cpu_done_o[1]), .io_done(io_done_o[1]), .busy(busy_o[1]),
        .grant_io(grant_io_o[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline of one transaction sampled at cycle N, t = cycles since N:
    // read  : mem_en t=1..W+2, mdr t=W+2 (cpu), done t=W+3
    // write : mem_en/mem_we t=1..W+1, done t=W+2
    function automatic int done_t(int k);
        return m_we[k] ? W[k] + 2 : W[k] + 3;
    endfunction

    task automatic model_step(int k);
        bit pick;
        if (reset) begin
            m_act[k] = 0; m_t[k] = 0; m_own[k] = 0; m_we[k] = 0; m_last[k] = 1;
            m_addr[k] = 0; m_wdata[k] = 0; m_rd[k] = 0;
        end else if (m_act[k]) begin
            if (!m_we[k] && m_own[k] && m_t[k] == W[k] + 2) m_rd[k] = mem_rdata;
            if (m_t[k] == done_t(k)) begin
                m_last[k] = m_own[k];
                m_act[k]  = 0;
            end else m_t[k]++;
        end else if (cpu_req || io_req) begin
            pick = io_req && (!cpu_req || !m_last[k]);
            m_own[k]   = pick;
            m_we[k]    = pick ? io_we : cpu_we;
            m_addr[k]  = pick ? io_addr : cpu_addr;
            m_wdata[k] = pick ? io_wdata : cpu_wdata;
            m_act[k]   = 1;
            m_t[k]     = 1;
        end
    endtask

    task automatic compare(int k);
        bit a;
        int t;
        a = m_act[k];
        t = m_t[k];
        chk($sformatf("busy[%0d]", k), busy_o[k], a);
        chk($sformatf("mem_en[%0d]", k), mem_en_o[k],
            a && t <= (m_we[k] ? W[k] + 1 : W[k] + 2));
        chk($sformatf("mem_we[%0d]", k), mem_we_o[k], a && m_we[k] && t <= W[k] + 1);
        chk($sformatf("mdr_read[%0d]", k), mdr_read_o[k],
            a && !m_we[k] && !m_own[k] && t == W[k] + 2);
        chk($sformatf("cpu_done[%0d]", k), cpu_done_o[k], a && !m_own[k] && t == done_t(k));
        chk($sformatf("io_done[%0d]", k), io_done_o[k], a && m_own[k] && t == done_t(k));
        chk($sformatf("grant_io[%0d]", k), grant_io_o[k], m_own[k]);
        chk($sformatf("mem_addr[%0d]", k), mem_addr_o[k], m_addr[k]);
        chk($sformatf("mem_wdata[%0d]", k), mem_wdata_o[k], m_wdata[k]);
        chk($sformatf("io_rdata[%0d]", k), io_rdata_o[k], m_rd[k]);
    endtask

    // model advance at each rising edge; compare and observe at each falling edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) model_step(k);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                compare(k);
                if (mem_en_o[k])   en_cnt[k]++;
                if (mem_we_o[k])   we_cnt[k]++;
                if (mdr_read_o[k]) mdr_cnt[k]++;
                if (cpu_done_o[k]) begin done_cnt[k]++; last_cpu_done[k] = cyc; end
                if (io_done_o[k])  begin done_cnt[k]++; rd_at_done[k] = io_rdata_o[k]; end
            end
            if (cpu_done_o[0]) order_q.push_back(0);
            if (io_done_o[0])  order_q.push_back(1);
        end
    end

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            en_cnt[k] = 0; we_cnt[k] = 0; mdr_cnt[k] = 0; done_cnt[k] = 0;
            last_cpu_done[k] = -1; rd_at_done[k] = 8'h00;
        end
    endtask

    task automatic zero_outs(input string name);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s[%0d]", name, k),
                {mem_en_o[k], mem_we_o[k], mdr_read_o[k], cpu_done_o[k], io_done_o[k],
                 busy_o[k], grant_io_o[k], mem_addr_o[k], mem_wdata_o[k], io_rdata_o[k]}, 0);
    endtask

    initial begin
        int n, r, d;
        next_cyc();
        next_cyc();
        zero_outs("reset_state");
        reset = 0;
        next_cyc();

        // cpu read of 0x20; address input moves during ACCESS
        clr();
        mem_rdata = 8'h5A;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        n = cyc;
        next_cyc();
        cpu_req = 0; cpu_addr = 8'hFF;
        next_cyc();
        chk("w0_addr_held", mem_addr_o[1], 8'h20);
        repeat (6) next_cyc();
        chk("rd_done_w1", last_cpu_done[0], n + 4);
        chk("rd_done_w0", last_cpu_done[1], n + 3);
        chk("rd_en_w1", en_cnt[0], 3);
        chk("rd_en_w0", en_cnt[1], 2);
        chk("rd_mdr_w1", mdr_cnt[0], 1);
        chk("rd_mdr_w0", mdr_cnt[1], 1);

        // cpu write 0xA5 -> 0x10
        clr();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
        n = cyc;
        next_cyc();
        cpu_req = 0; cpu_wdata = 8'h00;
        repeat (6) next_cyc();
        chk("wr_done", last_cpu_done[0], n + 3);
        chk("wr_we_cycles", we_cnt[0], 2);
        chk("wr_mdr", mdr_cnt[0], 0);
        chk("wr_addr", mem_addr_o[0], 8'h10);
        chk("wr_wdata", mem_wdata_o[0], 8'hA5);

        // io read of 0x33
        clr();
        mem_rdata = 8'hC3;
        io_req = 1; io_we = 0; io_addr = 8'h33;
        next_cyc();
        io_req = 0;
        repeat (6) next_cyc();
        chk("io_rdata_at_done", rd_at_done[0], 8'hC3);
        chk("io_rd_mdr", mdr_cnt[0], 0);

        // a cpu read must leave io_rdata untouched
        mem_rdata = 8'h00;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40;
        next_cyc();
        cpu_req = 0;
        repeat (6) next_cyc();
        chk("io_rdata_hold", io_rdata_o[0], 8'hC3);

        // fresh reset, then simultaneous requests: cpu wins the first tie
        reset = 1;
        next_cyc();
        reset = 0;
        order_q.delete();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h01; cpu_wdata = 8'h11;
        io_req  = 1; io_we  = 1; io_addr  = 8'h02; io_wdata  = 8'h22;
        repeat (16) next_cyc();
        cpu_req = 0; io_req = 0;
        repeat (5) next_cyc();
        chk("rr_count", order_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_owner%0d", i), (i < order_q.size()) ? order_q[i] : 9, i % 2);

        // reset during ACCESS of a held cpu read
        clr();
        mem_rdata = 8'h77;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h44;
        next_cyc();
        next_cyc();
        reset = 1;
        #1;
        zero_outs("abort_outs");
        next_cyc();
        next_cyc();
        d = done_cnt[0] + done_cnt[1];
        chk("abort_no_done", d, 0);
        reset = 0;
        r = cyc;
        next_cyc();
        cpu_req = 0;
        repeat (6) next_cyc();
        chk("restart_done", last_cpu_done[0], r + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, meaning extra memory cycles before read data is valid or a write completes (legal range 0..15).
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge system clock
- reset  input  1  asynchronous active-high reset
- cpu_req  input  1  control-unit request
- cpu_we  input  1  cpu write (1) / read (0)
- cpu_addr  input  8  cpu address (from MAR)
- cpu_wdata  input  8  cpu write data (from MDR data_out)
- io_req  input  1  I/O port request
- io_we  input  1  io write/read
- io_addr  input  8  io address
- io_wdata  input  8  io write data
- mem_rdata  input  8  data-memory read data
- mem_en  output  1  data-memory enable
- mem_we  output  1  data-memory write enable
- mem_addr  output  8  data-memory address
- mem_wdata  output  8  data-memory write data
- mdr_read  output  1  MDR capture strobe (MDR read input)
- io_rdata  output  8  io read-data register
- cpu_done  output  1  one-cycle cpu completion pulse
- io_done  output  1  one-cycle io completion pulse
- busy  output  1  high in any state other than IDLE
- grant_io  output  1  current/last owner: 0 = cpu, 1 = io

Function
REQ-003 The block SHALL implement FSM states IDLE, ACCESS, CAPTURE, DONE, changing only on rising clk.
REQ-004 In IDLE with any request high, the block SHALL select an owner and latch owner, we, addr and wdata into internal registers, then go to ACCESS with wait counter = WAIT_CYCLES.
REQ-005 Arbitration SHALL be round-robin: single requester wins; on simultaneous requests the requester not served last wins; last-served resets to io, so cpu wins the first tie.
REQ-006 Requests and request fields SHALL be sampled only in IDLE; changes during ACCESS/CAPTURE/DONE SHALL be ignored.
REQ-007 In ACCESS, mem_en SHALL be 1 and mem_we SHALL equal the latched we; mem_addr and mem_wdata SHALL equal the latched values throughout the transaction.
REQ-008 In ACCESS with counter 0, the FSM SHALL go to DONE for a write and to CAPTURE for a read; otherwise the counter SHALL decrement and the FSM SHALL stay in ACCESS.
REQ-009 In CAPTURE, mem_en SHALL be 1 and mem_we SHALL be 0.
REQ-010 In CAPTURE, mdr_read SHALL be 1 for exactly one cycle if the owner is cpu; if the owner is io, io_rdata SHALL load mem_rdata at the end of the cycle.
REQ-011 In DONE, the owner's done output SHALL be 1 for exactly one cycle, last-served SHALL update to the owner, and the FSM SHALL return to IDLE.
REQ-012 Latency from request sampled in IDLE at cycle N SHALL be: done at cycle N+3+WAIT_CYCLES for a read and N+2+WAIT_CYCLES for a write.
REQ-013 A request still high in the IDLE cycle after done SHALL be treated as a new transaction.
REQ-014 mem_en, mem_we, mdr_read, cpu_done, io_done and busy SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-015 mem_en SHALL be 0 in IDLE and DONE.
REQ-016 io_rdata SHALL hold its value between io reads.

Reset
REQ-017 On reset high, asynchronously: state SHALL be IDLE; mem_en, mem_we, mdr_read, cpu_done, io_done, busy and grant_io SHALL be 0; mem_addr, mem_wdata and io_rdata SHALL be 8'h00; last-served SHALL be io; counter SHALL be 0.
REQ-018 Reset asserted mid-transaction SHALL abort it with no done pulse and no mdr_read; after release, the block SHALL re-arbitrate from IDLE.

Verification
REQ-019 With WAIT_CYCLES=1, a cpu read of 8'h20 with mem_rdata=8'h5A SHALL give mem_en for 3 cycles, mdr_read 1 cycle in CAPTURE, and cpu_done at N+4.
REQ-020 A cpu write of 8'hA5 to 8'h10 SHALL give mem_we=1 for 2 ACCESS cycles, mem_addr 8'h10, mem_wdata 8'hA5, cpu_done at N+3, and no mdr_read.
REQ-021 cpu_req and io_req held high together for 4 transactions SHALL produce owner order cpu, io, cpu, io, with grant_io toggling.
REQ-022 An io read of 8'h33 with mem_rdata=8'hC3 SHALL give io_rdata=8'hC3 at io_done, with mdr_read staying 0.
REQ-023 Reset pulsed during ACCESS of a cpu read SHALL force all outputs 0 immediately, with no cpu_done; a held request SHALL restart after release.
REQ-024 With WAIT_CYCLES=0, a read SHALL complete at N+3, and cpu_addr changed during ACCESS SHALL not change mem_addr.
